// File: rtl/turbo_pkg.sv
// Shared turbo-code definitions: LTE constituent polynomials and the RSC FSM encoding.
package turbo_pkg;

    // LTE constituent code: memory 3, g0 = 1+D^2+D^3 (feedback), g1 = 1+D+D^3 (parity)
    localparam int         M_LTE    = 3;
    localparam logic [3:0] G_FB_LTE = 4'b1101;
    localparam logic [3:0] G_FF_LTE = 4'b1011;

    // Encoder control states: waiting for a block, encoding information bits, emitting tail
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2
    } rsc_state_t;

endpackage

// File: rtl/rsc_step.sv
// One trellis step of a recursive systematic convolutional encoder.
// In tail mode the input bit is replaced by the feedback sum, which zeroes the
// recursive bit and shifts a zero into the state register.
module rsc_step #(
    parameter int           M    = 3,
    parameter logic [M:0]   G_FB = 4'b1101,
    parameter logic [M:0]   G_FF = 4'b1011
) (
    input  logic [M-1:0] s,
    input  logic         x,
    input  logic         tail,
    output logic         sys,
    output logic         par,
    output logic [M-1:0] s_next
);

    logic fb_sum;
    logic ff_sum;
    logic x_eff;
    logic a;

    // Feedback/feedforward sums over the state taps, then systematic, parity and next state
    always_comb begin
        fb_sum = 1'b0;
        ff_sum = 1'b0;
        for (int i = 1; i <= M; i++) begin
            fb_sum = fb_sum ^ (G_FB[i] & s[i-1]);
            ff_sum = ff_sum ^ (G_FF[i] & s[i-1]);
        end
        x_eff  = tail ? fb_sum : x;
        a      = x_eff ^ fb_sum;
        sys    = x_eff;
        par    = (G_FF[0] & a) ^ ff_sum;
        s_next = {s[M-2:0], a};
    end

endmodule

// File: rtl/rsc_conv_encoder.sv
// Terminated RSC constituent encoder with a valid/ready input stream and a
// single-register output slot, parallel or serial symbol format.
//
// Handshake: a beat transfers on a rising clk edge where valid and ready are both
// high; ready never depends on the same interface's valid, and a presented beat
// (out_data/out_tail/out_last) holds stable until it transfers.
module rsc_conv_encoder
    import turbo_pkg::*;
#(
    parameter int         M      = M_LTE,
    parameter logic [M:0] G_FB   = G_FB_LTE,
    parameter logic [M:0] G_FF   = G_FF_LTE,
    parameter int         LEN_W  = 13,
    parameter int         SERIAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic [LEN_W-1:0] blk_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_data,
    output logic             out_tail,
    output logic             out_last,
    output logic             busy
);

    localparam int TC_W = $clog2(M + 1);

    rsc_state_t       state_q, state_d;
    logic [M-1:0]     s_q;
    logic [LEN_W-1:0] cnt_q;
    logic [TC_W-1:0]  tail_cnt_q;
    logic             valid_q;
    logic             sys_q;
    logic             par_q;
    logic             tail_q;
    logic             last_q;
    logic             phase_q;

    logic             final_beat;
    logic             slot_free;
    logic             fire;
    logic             start_ok;
    logic             accept;
    logic             tail_gen;
    logic             load;
    logic             done;
    logic             step_sys;
    logic             step_par;
    logic [M-1:0]     s_next;

    rsc_step #(
        .M    (M),
        .G_FB (G_FB),
        .G_FF (G_FF)
    ) u_step (
        .s      (s_q),
        .x      (in_bit),
        .tail   (state_q == TAIL),
        .sys    (step_sys),
        .par    (step_par),
        .s_next (s_next)
    );

    // Slot and handshake qualifiers; the slot frees on the transfer of a symbol's final beat
    always_comb begin
        final_beat = (SERIAL != 0) ? phase_q : 1'b1;
        slot_free  = !valid_q || (out_ready && final_beat);
        fire       = valid_q && out_ready;
        start_ok   = (state_q == IDLE) && start && (blk_len != '0);
        in_ready   = en && (state_q == DATA) && slot_free;
        accept     = in_valid && in_ready;
        tail_gen   = (state_q == TAIL) && slot_free && (tail_cnt_q != TC_W'(M));
        load       = accept || tail_gen;
        done       = fire && final_beat && last_q;
    end

    // Next-state logic for the block sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = DATA;
            DATA:    if (accept && (cnt_q == LEN_W'(1))) state_d = TAIL;
            TAIL:    if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state register; en low returns to IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else if (!en) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Encoder state, remaining-bit counter and tail counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q        <= '0;
            cnt_q      <= '0;
            tail_cnt_q <= '0;
        end else if (!en) begin
            s_q        <= '0;
            cnt_q      <= '0;
            tail_cnt_q <= '0;
        end else if (start_ok) begin
            s_q        <= '0;
            cnt_q      <= blk_len;
            tail_cnt_q <= '0;
        end else begin
            if (accept)   cnt_q      <= cnt_q - LEN_W'(1);
            if (load)     s_q        <= s_next;
            if (tail_gen) tail_cnt_q <= tail_cnt_q + TC_W'(1);
        end
    end

    // Output slot: load a new symbol when free, otherwise step the serial phase or drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            sys_q   <= 1'b0;
            par_q   <= 1'b0;
            tail_q  <= 1'b0;
            last_q  <= 1'b0;
            phase_q <= 1'b0;
        end else if (!en) begin
            valid_q <= 1'b0;
            sys_q   <= 1'b0;
            par_q   <= 1'b0;
            tail_q  <= 1'b0;
            last_q  <= 1'b0;
            phase_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            sys_q   <= step_sys;
            par_q   <= step_par;
            tail_q  <= tail_gen;
            last_q  <= tail_gen && (tail_cnt_q == TC_W'(M - 1));
            phase_q <= 1'b0;
        end else if (fire) begin
            if (final_beat) begin
                valid_q <= 1'b0;
                phase_q <= 1'b0;
            end else begin
                phase_q <= 1'b1;
            end
        end
    end

    // Output formatting; everything reads 0 while the slot is empty
    always_comb begin
        out_valid = valid_q;
        out_tail  = valid_q && tail_q;
        out_last  = valid_q && last_q && final_beat;
        busy      = (state_q != IDLE);
        if (!valid_q) begin
            out_data = 2'b00;
        end else if (SERIAL != 0) begin
            out_data = {1'b0, (phase_q ? par_q : sys_q)};
        end else begin
            out_data = {par_q, sys_q};
        end
    end

endmodule

// File: tb/tb_rsc_conv_encoder.sv
// Directed bench for the RSC encoder: a parallel instance exercises block flow,
// stalls, en and start handling; a serial instance checks beat ordering.
module tb_rsc_conv_encoder;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        start;
    logic [12:0] blk_len;
    logic        in_valid;
    logic        in_ready;
    logic        in_bit;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_data;
    logic        out_tail;
    logic        out_last;
    logic        busy;

    logic        s_start;
    logic [12:0] s_blk_len;
    logic        s_in_valid;
    logic        s_in_ready;
    logic        s_in_bit;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [1:0]  s_out_data;
    logic        s_out_tail;
    logic        s_out_last;
    logic        s_busy;

    int n_cmp;
    int n_fail;

    // entries are {last, tail, out_data[1:0]}
    logic [3:0] exp_q[$];
    logic [3:0] got_q[$];
    logic [3:0] s_got_q[$];

    rsc_conv_encoder #(.SERIAL(0)) dut_p (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .blk_len(blk_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tail(out_tail), .out_last(out_last), .busy(busy)
    );

    rsc_conv_encoder #(.SERIAL(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .en(en), .start(s_start), .blk_len(s_blk_len),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_bit(s_in_bit),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_tail(s_out_tail), .out_last(s_out_last), .busy(s_busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // beat monitors, sampled mid-cycle
    always @(negedge clk) begin
        if (out_valid && out_ready) got_q.push_back({out_last, out_tail, out_data});
        if (s_out_valid && s_out_ready) s_got_q.push_back({s_out_last, s_out_tail, s_out_data});
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [12:0] len);
        start   = 1'b1;
        blk_len = len;
        cyc();
        start   = 1'b0;
    endtask

    // LTE reference: a = x ^ s1 ^ s2, p = a ^ s0 ^ s2, tail x = s1 ^ s2
    task automatic build_exp(input logic [63:0] d, input int n);
        logic [2:0] st;
        logic fb, x, a, p, tl;
        exp_q.delete();
        st = 3'b000;
        for (int k = 0; k < n + 3; k++) begin
            tl = (k >= n);
            fb = st[1] ^ st[2];
            x  = tl ? fb : d[k];
            a  = x ^ fb;
            p  = a ^ st[0] ^ st[2];
            st = {st[1:0], a};
            exp_q.push_back({(k == n + 2), tl, p, x});
        end
    endtask

    // drives one started block to its out_last handshake; optional stall window,
    // extra start pulse at restart_at, and start raised on the out_last cycle
    task automatic run_block(input logic [63:0] d, input int n, input int stall_at,
                             input int stall_len, input int restart_at, input bit start_on_last,
                             output bit timeout, output int viol);
        int i;
        int cyc_n;
        bit fin;
        logic [3:0] held;
        i = 0; cyc_n = 0; fin = 1'b0; viol = 0; held = '0;
        while (!fin && cyc_n < 500) begin
            in_valid  = (i < n);
            in_bit    = (i < n) ? d[i] : 1'b0;
            out_ready = !(cyc_n >= stall_at && cyc_n < stall_at + stall_len);
            start     = (cyc_n == restart_at);
            if (cyc_n == restart_at) blk_len = 13'd5;
            #1;
            if (!out_ready) begin
                if (in_ready !== 1'b0) viol++;
                if (cyc_n == stall_at) held = {out_last, out_tail, out_data};
                else if ({out_last, out_tail, out_data} !== held) viol++;
            end
            if (in_valid && in_ready) i++;
            if (out_valid && out_ready && out_last) begin
                fin = 1'b1;
                if (start_on_last) begin
                    start   = 1'b1;
                    blk_len = 13'd4;
                end
            end
            cyc();
            cyc_n++;
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        timeout   = !fin;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #23;
        n_cmp++;
        if ({in_ready, out_valid, out_data, out_tail, out_last, busy} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_par got %b exp 0000000", {in_ready, out_valid, out_data, out_tail, out_last, busy});
        end
        n_cmp++;
        if ({s_in_ready, s_out_valid, s_out_data, s_out_tail, s_out_last, s_busy} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_ser got %b exp 0000000", {s_in_ready, s_out_valid, s_out_data, s_out_tail, s_out_last, s_busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_impulse_parallel();
        bit to; int viol;
        exp_q = '{4'b0011, 4'b0110, 4'b0101, 4'b1111};
        got_q.delete();
        do_start(13'd1);
        run_block(64'd1, 1, -10, 0, -1, 1'b0, to, viol);
        n_cmp++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL impulse_timeout got %b exp 0", to); end
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL impulse_count got %0d exp %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_cmp++;
            if (got_q[k] !== exp_q[k]) begin
                n_fail++; $display("FAIL impulse_sym[%0d] got %b exp %b", k, got_q[k], exp_q[k]);
            end
        end
        n_cmp++;
        if (dut_p.s_q !== 3'b000) begin n_fail++; $display("FAIL impulse_final_s got %b exp 000", dut_p.s_q); end
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL impulse_busy got %b exp 0", busy); end
    endtask

    task automatic test_all_zero();
        bit to; int viol; int tails;
        exp_q.delete();
        for (int k = 0; k < 40; k++) exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1100);
        got_q.delete();
        do_start(13'd40);
        run_block(64'd0, 40, -10, 0, -1, 1'b0, to, viol);
        n_cmp++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL zero_timeout got %b exp 0", to); end
        n_cmp++;
        if (got_q.size() != 43) begin n_fail++; $display("FAIL zero_count got %0d exp 43", got_q.size()); end
        tails = 0;
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            if (got_q[k][2]) tails++;
            n_cmp++;
            if (got_q[k] !== exp_q[k]) begin
                n_fail++; $display("FAIL zero_sym[%0d] got %b exp %b", k, got_q[k], exp_q[k]);
            end
        end
        n_cmp++;
        if (tails != 3) begin n_fail++; $display("FAIL zero_tails got %0d exp 3", tails); end
        n_cmp++;
        if (dut_p.s_q !== 3'b000) begin n_fail++; $display("FAIL zero_final_s got %b exp 000", dut_p.s_q); end
    endtask

    task automatic test_backpressure();
        bit to; int viol; logic [63:0] d;
        d = {$urandom(), $urandom()};
        build_exp(d, 40);
        got_q.delete();
        do_start(13'd40);
        run_block(d, 40, 15, 3, -1, 1'b0, to, viol);
        n_cmp++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL bp_timeout got %b exp 0", to); end
        n_cmp++;
        if (viol != 0) begin n_fail++; $display("FAIL bp_stall_hold got %0d violations exp 0", viol); end
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL bp_count got %0d exp %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_cmp++;
            if (got_q[k] !== exp_q[k]) begin
                n_fail++; $display("FAIL bp_sym[%0d] got %b exp %b", k, got_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_en_drop();
        bit to; int viol; int i; int cyc_n; logic [63:0] d;
        d = {$urandom(), $urandom()};
        build_exp(d, 40);
        do_start(13'd40);
        i = 0; cyc_n = 0;
        while (i < 10 && cyc_n < 100) begin
            in_valid = 1'b1; in_bit = d[i]; out_ready = 1'b1;
            #1;
            if (in_ready) i++;
            cyc();
            cyc_n++;
        end
        n_cmp++;
        if (i != 10) begin n_fail++; $display("FAIL en_partial_accepts got %0d exp 10", i); end
        en = 1'b0;
        in_valid = 1'b0;
        cyc();
        n_cmp++;
        if ({in_ready, out_valid, out_data, out_tail, out_last, busy} !== 7'd0) begin
            n_fail++;
            $display("FAIL en_drop_outputs got %b exp 0000000", {in_ready, out_valid, out_data, out_tail, out_last, busy});
        end
        n_cmp++;
        if (dut_p.s_q !== 3'b000) begin n_fail++; $display("FAIL en_drop_s got %b exp 000", dut_p.s_q); end
        en = 1'b1;
        cyc();
        got_q.delete();
        do_start(13'd40);
        run_block(d, 40, -10, 0, -1, 1'b0, to, viol);
        n_cmp++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL en_rerun_timeout got %b exp 0", to); end
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL en_rerun_count got %0d exp %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_cmp++;
            if (got_q[k] !== exp_q[k]) begin
                n_fail++; $display("FAIL en_rerun_sym[%0d] got %b exp %b", k, got_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_ignored_starts();
        bit to; int viol; logic [63:0] d;
        do_start(13'd0);
        n_cmp++;
        if ({busy, in_ready} !== 2'b00) begin
            n_fail++; $display("FAIL ign_len0 got busy,in_ready=%b exp 00", {busy, in_ready});
        end
        d = 64'h00000000_000000B5;
        build_exp(d, 8);
        got_q.delete();
        do_start(13'd8);
        run_block(d, 8, -10, 0, 3, 1'b0, to, viol);
        n_cmp++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL ign_timeout got %b exp 0", to); end
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL ign_count got %0d exp %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_cmp++;
            if (got_q[k] !== exp_q[k]) begin
                n_fail++; $display("FAIL ign_sym[%0d] got %b exp %b", k, got_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit to; int viol; logic [63:0] d;
        d = 64'h00000000_0000002D;
        build_exp(d, 6);
        got_q.delete();
        do_start(13'd6);
        run_block(d, 6, -10, 0, -1, 1'b1, to, viol);
        n_cmp++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL b2b_a_timeout got %b exp 0", to); end
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_start_on_last_busy got %b exp 0", busy); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_cmp++;
            if (got_q[k] !== exp_q[k]) begin
                n_fail++; $display("FAIL b2b_a_sym[%0d] got %b exp %b", k, got_q[k], exp_q[k]);
            end
        end
        d = 64'h00000000_0000000B;
        build_exp(d, 4);
        got_q.delete();
        do_start(13'd4);
        n_cmp++;
        if ({busy, in_ready} !== 2'b11) begin
            n_fail++; $display("FAIL b2b_restart got busy,in_ready=%b exp 11", {busy, in_ready});
        end
        run_block(d, 4, -10, 0, -1, 1'b0, to, viol);
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL b2b_b_count got %0d exp %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_cmp++;
            if (got_q[k] !== exp_q[k]) begin
                n_fail++; $display("FAIL b2b_b_sym[%0d] got %b exp %b", k, got_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_impulse_serial();
        int i; int cyc_n; bit fin;
        exp_q = '{4'b0001, 4'b0001, 4'b0100, 4'b0101, 4'b0101, 4'b0100, 4'b0101, 4'b1101};
        s_got_q.delete();
        s_start = 1'b1; s_blk_len = 13'd1;
        cyc();
        s_start = 1'b0;
        i = 0; cyc_n = 0; fin = 1'b0;
        while (!fin && cyc_n < 60) begin
            s_in_valid = (i < 1); s_in_bit = 1'b1; s_out_ready = 1'b1;
            #1;
            if (s_in_valid && s_in_ready) i++;
            if (s_out_valid && s_out_last) fin = 1'b1;
            cyc();
            cyc_n++;
        end
        s_in_valid = 1'b0;
        n_cmp++;
        if (fin !== 1'b1) begin n_fail++; $display("FAIL ser_timeout got %b exp 1", fin); end
        n_cmp++;
        if (s_got_q.size() != 8) begin n_fail++; $display("FAIL ser_count got %0d exp 8", s_got_q.size()); end
        for (int k = 0; k < exp_q.size() && k < s_got_q.size(); k++) begin
            n_cmp++;
            if (s_got_q[k] !== exp_q[k]) begin
                n_fail++; $display("FAIL ser_beat[%0d] got %b exp %b", k, s_got_q[k], exp_q[k]);
            end
        end
        n_cmp++;
        if (s_busy !== 1'b0) begin n_fail++; $display("FAIL ser_busy got %b exp 0", s_busy); end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        en = 1'b1; start = 1'b0; blk_len = '0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b1;
        s_start = 1'b0; s_blk_len = '0; s_in_valid = 1'b0; s_in_bit = 1'b0; s_out_ready = 1'b1;
        test_reset();
        test_impulse_parallel();
        test_all_zero();
        test_backpressure();
        test_en_drop();
        test_ignored_starts();
        test_back_to_back();
        test_impulse_serial();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rsc_conv_encoder.md
# rsc_conv_encoder

Parametrised recursive systematic convolutional (RSC) encoder: the constituent-encoder building block of the turbo encoder, replacing the fixed 4-state, non-terminated encoder. It accepts a block of information bits over a valid/ready stream and emits one systematic+parity symbol per bit. It then appends M trellis-termination (tail) symbols that drive the encoder state back to zero. Output is either a parallel 2-bit symbol or a sys-then-parity serial bit stream.

## Interface
- `M`, 3: encoder memory; number of states is 2^M; number of tail symbols is M (M ≥ 2).
- `G_FB`, 4'b1101: feedback polynomial, bit i is the coefficient of D^i; bit 0 must be 1. Default is 1+D²+D³ (LTE g0).
- `G_FF`, 4'b1011: feedforward (parity) polynomial, bit i is the coefficient of D^i. Default is 1+D+D³ (LTE g1).
- `LEN_W`, 13: width of the block-length input.
- `SERIAL`, 0: 0 = one 2-bit symbol per beat; 1 = two 1-bit beats per symbol.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `en`  in  1  synchronous enable; when low, clears all state, with priority over everything except `rst_n`.
- `start`  in  1  one-cycle pulse that begins a block.
- `blk_len`  in  LEN_W  number of information bits; sampled on an accepted `start`.
- `in_valid`  in  1  `in_bit` is valid.
- `in_ready`  out  1  the encoder takes `in_bit` this cycle.
- `in_bit`  in  1  information bit.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  the consumer takes `out_data` this cycle.
- `out_data`  out  2  parallel mode: {parity, sys}; serial mode: bit 0 carries the bit and bit 1 is 0.
- `out_tail`  out  1  the current beat belongs to a tail symbol.
- `out_last`  out  1  the current beat is the final beat of the block.
- `busy`  out  1  a block is in progress.

## Operation
- **State register.** `s[M-1:0]`, where `s[0]` is the newest element.
- **Feedback.** a = x ^ XOR over i=1..M of (G_FB[i] & s[i-1]).
- **Parity.** p = (G_FF[0] & a) ^ XOR over i=1..M of (G_FF[i] & s[i-1]).
- **Next state.** {s[M-2:0], a}.
- **Data symbols.** x = `in_bit`; the symbol is sys = x, parity = p.
- **Tail symbols.** x = XOR over i=1..M of (G_FB[i] & s[i-1]), which forces a = 0. The symbol is sys = x, parity = p. After M tail symbols, s = 0.
- **FSM states.** IDLE, DATA, TAIL.
  - IDLE → DATA on `start` with `blk_len` ≠ 0. This loads the bit counter and clears s.
  - DATA → TAIL when the `blk_len`-th bit is accepted.
  - TAIL → IDLE when the last beat of the M-th tail symbol completes its handshake.
- **Ignored starts.** `start` is ignored while `busy`=1 or when `blk_len`=0.
- **Output slot.** A single output register holds the current symbol. The slot is free when `out_valid`=0, or when `out_ready`=1 on the final beat of the symbol.
- **in_ready.** in_ready = (state == DATA) & slot free.
- **Tail generation.** In TAIL, one tail symbol is generated whenever the slot is free.
- **Serial mode.** Beat 0 carries sys and beat 1 carries parity. A phase bit advances only on an `out_valid & out_ready` handshake.
- **out_last.** Set only on the final beat of the last tail symbol.
- **out_tail.** Set on every beat of every tail symbol.
- **Backpressure.** While `out_valid & !out_ready`, `out_data`, `out_tail` and `out_last` hold stable.
- **busy.** Rises the cycle after `start` is accepted; falls the cycle after the `out_last` handshake.

## Timing
- **Reset.** `rst_n` low (asynchronous) and `en` low (synchronous) produce identical results: FSM = IDLE, s = 0, counters = 0. All outputs read 0: `in_ready`, `out_valid`, `out_data`, `out_tail`, `out_last`, `busy`.
- **Latency.** A bit accepted in cycle t gives `out_valid` = 1 in cycle t+1.
- **Throughput.** 1 symbol per cycle in parallel mode; 1 symbol per 2 cycles in serial mode.
- **Back-to-back blocks.**
  - A `start` in the same cycle as the `out_last` handshake is ignored, because `busy` is still 1.
  - The earliest accepted `start` is the cycle after `busy` falls.
  - The first `in_ready` is the cycle after the accepted `start`.
- **en mid-block.** Dropping `en` mid-block discards the block; the next cycle shows reset values.
- **Block length.** `blk_len` = 2^LEN_W − 1 is the largest block; the counter must not wrap.

## Structure
- **Shared package `turbo_pkg`.**
  - LTE polynomial constants (`G_FB_LTE`, `G_FF_LTE`, `M_LTE`).
  - FSM enum `rsc_state_t` {IDLE, DATA, TAIL}.
- **Sub-module `rsc_step`.** Purely combinational; parametrised by M, G_FB and G_FF.
  - Inputs: `s`, `x`, `tail`.
  - Outputs: `sys`, `par`, `s_next`.
  - Reused later by the trellis termination in the interleaved second constituent.

## Test plan
- **Impulse, parallel.** Defaults, SERIAL=0, `out_ready`=1, `blk_len`=1, `in_bit`=1.
  - Symbols {par,sys}: (1,1), then tails (1,0), (0,1), (1,1).
  - `out_tail` high on symbols 2–4; `out_last` only on symbol 4.
  - Final s = 0.
- **All-zero block.** `blk_len`=40, all-zero input → 43 symbols, all 2'b00; 3 of them have `out_tail`=1; final s = 0.
- **Backpressure.** Random 40-bit block with `out_ready` low for 3 cycles mid-block.
  - `out_data` holds stable and `in_ready` stays 0 throughout.
  - The symbol stream is identical to a golden model with no stalls.
- **Impulse, serial.** SERIAL=1, same impulse as the first scenario.
  - Beats: 1,1, 0,1, 1,0, 1,1 (sys first in each pair).
  - `out_last` only on beat 8.
- **en dropped mid-block.** Deassert `en` after 10 of 40 bits.
  - Next cycle: all outputs 0 and `busy`=0.
  - A fresh block of the same data reproduces the golden output exactly.
- **Ignored starts.** `start` while `busy`, and `start` with `blk_len`=0 → both ignored; the current block completes unchanged.
